sha1_padder: RTL and testbench

Upstream stage of the SHA-1 core. It accepts a message as a byte stream and applies FIPS 180 padding: append `0x80`, zero-fill, then a 64-bit big-endian bit length. It emits 512-bit blocks in exactly the lane order the core expects on `SHA1IN`: message byte i of the block goes to bits `[8*i +: 8]`. It also supplies the start strobe and the first/last flags that chaining logic needs.

---
 rtl/sha1_pkg.sv | 26 ++
 rtl/sha1_padder.sv | 136 +++++++++++++
 tb/tb_sha1_padder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// Constants and types shared by the SHA-1 padder and the SHA-1 core.
package sha1_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_LEN  = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam int         LEN_LANE    = 56;
  localparam int         BLOCK_BYTES = 64;

  localparam logic [31:0] SHA1_H0 = 32'h67452301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
  localparam logic [31:0] SHA1_H3 = 32'h10325476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

  localparam logic [31:0] SHA1_K0 = 32'h5A827999;
  localparam logic [31:0] SHA1_K1 = 32'h6ED9EBA1;
  localparam logic [31:0] SHA1_K2 = 32'h8F1BBCDC;
  localparam logic [31:0] SHA1_K3 = 32'hCA62C1D6;

endpackage

// File: rtl/sha1_padder.sv
// Byte-stream to 512-bit block padder in front of the SHA-1 core.
// Byte i of a block sits at BLOCK[8*i +: 8]; the 64-bit bit length is
// written big-endian into lanes 56..63.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [7:0]   DIN,
  input  logic         DIN_VALID,
  input  logic         DIN_LAST,
  output logic         DIN_READY,
  output logic [511:0] BLOCK,
  output logic         BLK_VALID,
  output logic         BLK_FIRST,
  output logic         BLK_LAST,
  input  logic         BLK_READY
);

  state_e             state_q, state_d;
  logic [511:0]       blk_q;
  logic [5:0]         p_q;
  logic [LEN_W-1:0]   len_q;
  logic               first_q;
  logic               last_q;
  logic               pad_pend_q;
  logic               len_pend_q;
  logic               byte_acc;
  logic               blk_acc;
  logic               at_end;

  // Zero-extend the bit count to 64 bits and byte-swap it so that lane 63
  // carries the least significant byte.
  function automatic logic [63:0] len_lanes(input logic [LEN_W-1:0] l);
    logic [63:0] l64;
    logic [63:0] r;
    l64 = 64'(l);
    for (int k = 0; k < 8; k++) r[8*k +: 8] = l64[8*(7-k) +: 8];
    return r;
  endfunction

  assign byte_acc  = (state_q == ST_FILL) && DIN_VALID;
  assign blk_acc   = (state_q == ST_EMIT) && BLK_READY;
  assign at_end    = (p_q == 6'(BLOCK_BYTES - 1));

  assign DIN_READY = (state_q == ST_FILL);
  assign BLK_VALID = (state_q == ST_EMIT);
  assign BLOCK     = blk_q;
  assign BLK_FIRST = first_q;
  assign BLK_LAST  = last_q;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (byte_acc) begin
          if (at_end)        state_d = ST_EMIT;
          else if (DIN_LAST) state_d = ST_PAD;
        end
      end
      ST_PAD:  state_d = ST_EMIT;
      ST_LEN:  state_d = ST_EMIT;
      ST_EMIT: begin
        if (blk_acc) begin
          if (len_pend_q)      state_d = ST_LEN;
          else if (pad_pend_q) state_d = ST_PAD;
          else                 state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Block buffer, lane pointer, bit counter and block flags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      blk_q      <= '0;
      p_q        <= '0;
      len_q      <= '0;
      first_q    <= 1'b1;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      len_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (byte_acc) begin
            blk_q[{p_q, 3'b000} +: 8] <= DIN;
            p_q                       <= p_q + 6'd1;
            len_q                     <= len_q + LEN_W'(8);
            if (at_end) begin
              last_q     <= 1'b0;
              pad_pend_q <= DIN_LAST;
            end
          end
        end
        ST_PAD: begin
          blk_q[{p_q, 3'b000} +: 8] <= PAD_BYTE;
          pad_pend_q                <= 1'b0;
          if (p_q <= 6'(LEN_LANE - 1)) begin
            blk_q[511:448] <= len_lanes(len_q);
            last_q         <= 1'b1;
          end else begin
            last_q     <= 1'b0;
            len_pend_q <= 1'b1;
          end
        end
        ST_LEN: begin
          blk_q[511:448] <= len_lanes(len_q);
          last_q         <= 1'b1;
          len_pend_q     <= 1'b0;
        end
        ST_EMIT: begin
          if (blk_acc) begin
            blk_q   <= '0;
            p_q     <= '0;
            first_q <= last_q;
            last_q  <= 1'b0;
            if (last_q) len_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Bench for sha1_padder: directed and randomized messages against a
// byte-level padding model.
module tb_sha1_padder;

  logic         CLK;
  logic         nRST;
  logic [7:0]   DIN;
  logic         DIN_VALID;
  logic         DIN_LAST;
  logic         DIN_READY;
  logic [511:0] BLOCK;
  logic         BLK_VALID;
  logic         BLK_FIRST;
  logic         BLK_LAST;
  logic         BLK_READY;

  int total = 0;
  int bad   = 0;

  logic [7:0]   msg[$];
  logic [511:0] cap[$];

  sha1_padder #(.LEN_W(64)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_LAST  (DIN_LAST),
    .DIN_READY (DIN_READY),
    .BLOCK     (BLOCK),
    .BLK_VALID (BLK_VALID),
    .BLK_FIRST (BLK_FIRST),
    .BLK_LAST  (BLK_LAST),
    .BLK_READY (BLK_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends msg[] and accepts every block, comparing against the padded
  // message built from the padding rules. hold: cycles to stall block 0.
  task automatic run_msg(input int hold, input bit rnd);
    logic [7:0]   pad[$];
    logic [63:0]  bl;
    logic [511:0] eb;
    int n, idx, blk, nblk, cyc, expect_at, hold_left;
    bit seen, chk_rdy;
    n = msg.size();
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bl = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bl[8*k +: 8]);
    nblk = pad.size() / 64;
    idx = 0; blk = 0; cyc = 0; expect_at = -1; seen = 0; chk_rdy = 0;
    hold_left = hold;
    cap.delete();
    while ((idx < n || blk < nblk) && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
      DIN_VALID = 1'b0; DIN_LAST = 1'b0; BLK_READY = 1'b0;
      chk("excl", 512'(DIN_READY && BLK_VALID), 512'(0));
      if (chk_rdy) begin
        chk("rdy_after_blk", 512'(DIN_READY), 512'(1));
        chk_rdy = 0;
      end
      if (BLK_VALID) begin
        for (int i = 0; i < 64; i++) eb[8*i +: 8] = pad[64*blk + i];
        chk("block", BLOCK, eb);
        chk("first", 512'(BLK_FIRST), 512'(blk == 0));
        chk("last", 512'(BLK_LAST), 512'(blk == nblk - 1));
        if (!seen) begin
          seen = 1;
          if (expect_at >= 0) begin
            chk("latency", 512'(cyc), 512'(expect_at));
            expect_at = -1;
          end
        end
        if (blk == 0 && hold_left > 0) hold_left--;
        else if (!rnd || $urandom_range(0, 2) != 0) begin
          BLK_READY = 1'b1;
          cap.push_back(BLOCK);
          blk++;
          seen = 0;
          if (idx == n && blk < nblk) expect_at = cyc + 2;
          if (idx < n) chk_rdy = 1;
        end
      end else if (DIN_READY && idx < n) begin
        if (!rnd || $urandom_range(0, 3) != 0) begin
          DIN = msg[idx];
          DIN_VALID = 1'b1;
          DIN_LAST = (idx == n - 1);
          idx++;
          if (idx % 64 == 0) expect_at = cyc + 1;
          else if (idx == n) expect_at = cyc + 2;
        end
      end
    end
    chk("complete", 512'(idx == n && blk == nblk), 512'(1));
    @(negedge CLK);
    BLK_READY = 1'b0; DIN_VALID = 1'b0; DIN_LAST = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_block"}, BLOCK, 512'(0));
    chk({tag, "_valid"}, 512'(BLK_VALID), 512'(0));
    chk({tag, "_first"}, 512'(BLK_FIRST), 512'(1));
    chk({tag, "_last"}, 512'(BLK_LAST), 512'(0));
    chk({tag, "_ready"}, 512'(DIN_READY), 512'(1));
  endtask

  initial begin
    logic [511:0] b;
    logic [511:0] abc_blk;
    nRST = 1'b0; DIN = 8'h00; DIN_VALID = 1'b0; DIN_LAST = 1'b0; BLK_READY = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst0");
    nRST = 1'b1;
    @(negedge CLK);

    // "abc"
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(0, 0);
    b = cap[0];
    abc_blk = b;
    chk("abc_lo", 512'(b[31:0]), 512'(32'h80636261));
    chk("abc_hi", 512'(b[511:504]), 512'(8'h18));
    chk("abc_mid", 512'(b[503:32]), 512'(0));

    // 55 bytes of 0xAA
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'hAA);
    run_msg(0, 0);
    b = cap[0];
    chk("m55_lane55", 512'(b[8*55 +: 8]), 512'(8'h80));
    chk("m55_len", 512'(b[8*62 +: 16]), 512'(16'hB801));

    // 56 bytes
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    run_msg(0, 0);
    b = cap[0];
    chk("m56_lane56", 512'(b[8*56 +: 8]), 512'(8'h80));
    chk("m56_tail", 512'(b[511:456]), 512'(0));
    b = cap[1];
    chk("m56_blk2", b, {16'hC001, 496'(0)});

    // 64 bytes
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    run_msg(0, 0);
    b = cap[1];
    chk("m64_blk2", b, {16'h0002, 432'(0), 64'h80});

    // stall block 0 for 10 cycles, then a second message
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
    run_msg(10, 0);
    msg.delete();
    for (int i = 0; i < 7; i++) msg.push_back(8'($urandom));
    run_msg(0, 0);

    // randomized messages with bubbles and back-pressure
    for (int m = 0; m < 10; m++) begin
      int len;
      len = $urandom_range(1, 150);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg($urandom_range(0, 3), 1);
    end

    // reset mid-message
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      DIN = 8'($urandom); DIN_VALID = 1'b1; DIN_LAST = 1'b0;
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
    nRST = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge CLK);
    nRST = 1'b1;
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(0, 0);
    chk("abc_after_rst", cap[0], abc_blk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
